// File: rtl/ace_pkg.sv
// Shared ACE snoop types: snoop encodings, CR response layout, cache update ops, responder states.
package ace_pkg;

    // ACSNOOP encodings handled (or explicitly recognised) by the responder.
    typedef enum logic [3:0] {
        ACS_READ_ONCE             = 4'b0000,
        ACS_READ_SHARED           = 4'b0001,
        ACS_READ_CLEAN            = 4'b0010,
        ACS_READ_NOT_SHARED_DIRTY = 4'b0011,
        ACS_READ_UNIQUE           = 4'b0111,
        ACS_CLEAN_SHARED          = 4'b1000,
        ACS_CLEAN_INVALID         = 4'b1001,
        ACS_MAKE_INVALID          = 4'b1101,
        ACS_DVM_COMPLETE          = 4'b1110,
        ACS_DVM_MESSAGE           = 4'b1111
    } acsnoop_e;

    // CRRESP, MSB first: {WasUnique, IsShared, PassDirty, Error, DataTransfer}.
    typedef struct packed {
        logic was_unique;
        logic is_shared;
        logic pass_dirty;
        logic error;
        logic data_transfer;
    } cr_resp_t;

    // Local cache line state change requested after a snoop.
    typedef enum logic [1:0] {
        UPD_NONE         = 2'd0,
        UPD_CLEAN_SHARED = 2'd1,
        UPD_CLEAR_DIRTY  = 2'd2,
        UPD_INVALIDATE   = 2'd3
    } upd_op_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_WAIT   = 3'd2,
        ST_UPDATE = 3'd3,
        ST_RESP   = 3'd4
    } snoop_state_e;

endpackage

// File: rtl/ace_snoop_decode.sv
// Snoop decision table: maps (snoop type, hit, dirty, shared) to the CR response
// and the state change to apply to the local line.
//   snoop  in  4  ACSNOOP of the snoop in flight
//   hit    in  1  line present
//   dirty  in  1  line dirty
//   shared in  1  line shared
//   resp_c out    cr_resp_t response (combinational)
//   op_c   out    upd_op_e line update (combinational)
module ace_snoop_decode
    import ace_pkg::*;
(
    input  logic [3:0] snoop,
    input  logic       hit,
    input  logic       dirty,
    input  logic       shared,
    output cr_resp_t   resp_c,
    output upd_op_e    op_c
);

    // Misses and unsupported encodings (DVM included) answer all-zero with no state change.
    always_comb begin
        resp_c = '0;
        op_c   = UPD_NONE;
        if (hit) begin
            case (snoop)
                ACS_READ_ONCE: begin
                    resp_c.data_transfer = 1'b1;
                    resp_c.is_shared     = 1'b1;
                    resp_c.was_unique    = !shared;
                end
                ACS_READ_SHARED, ACS_READ_CLEAN, ACS_READ_NOT_SHARED_DIRTY: begin
                    resp_c.data_transfer = 1'b1;
                    resp_c.pass_dirty    = dirty;
                    resp_c.is_shared     = 1'b1;
                    resp_c.was_unique    = !shared;
                    op_c                 = UPD_CLEAN_SHARED;
                end
                ACS_READ_UNIQUE: begin
                    resp_c.data_transfer = 1'b1;
                    resp_c.pass_dirty    = dirty;
                    resp_c.was_unique    = !shared;
                    op_c                 = UPD_INVALIDATE;
                end
                ACS_CLEAN_INVALID: begin
                    resp_c.data_transfer = dirty;
                    resp_c.pass_dirty    = dirty;
                    resp_c.was_unique    = !shared;
                    op_c                 = UPD_INVALIDATE;
                end
                ACS_CLEAN_SHARED: begin
                    resp_c.data_transfer = dirty;
                    resp_c.pass_dirty    = dirty;
                    resp_c.is_shared     = 1'b1;
                    resp_c.was_unique    = !shared;
                    op_c                 = dirty ? UPD_CLEAR_DIRTY : UPD_NONE;
                end
                ACS_MAKE_INVALID: begin
                    resp_c.was_unique    = !shared;
                    op_c                 = UPD_INVALIDATE;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ace_snoop_responder.sv
// Cache-side ACE snoop responder: accepts one AC snoop at a time, looks the line up
// in the local cache, applies the resulting state change, then returns CR and (if
// data is transferred) the whole line on CD, lowest beat first.
//   clk, rst_n                      clock, asynchronous active-high reset
//   ac_valid_i/ac_ready_o, ac_*     snoop request channel
//   cr_valid_o/cr_ready_i, cr_resp_o snoop response channel
//   cd_valid_o/cd_ready_i, cd_*     snoop data channel
//   lookup_*                        cache tag/data lookup port
//   upd_*                           cache line state update port
module ace_snoop_responder
    import ace_pkg::*;
#(
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned WordWidth      = 64,
    parameter int unsigned CachelineWords = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                ac_valid_i,
    output logic                                ac_ready_o,
    input  logic [AddrWidth-1:0]                ac_addr_i,
    input  logic [3:0]                          ac_snoop_i,
    input  logic [2:0]                          ac_prot_i,
    output logic                                cr_valid_o,
    input  logic                                cr_ready_i,
    output logic [4:0]                          cr_resp_o,
    output logic                                cd_valid_o,
    input  logic                                cd_ready_i,
    output logic [DataWidth-1:0]                cd_data_o,
    output logic                                cd_last_o,
    output logic                                lookup_req_o,
    input  logic                                lookup_gnt_i,
    output logic [AddrWidth-1:0]                lookup_addr_o,
    input  logic                                lookup_rvalid_i,
    input  logic                                lookup_hit_i,
    input  logic                                lookup_dirty_i,
    input  logic                                lookup_shared_i,
    input  logic [CachelineWords*WordWidth-1:0] lookup_data_i,
    output logic                                upd_valid_o,
    input  logic                                upd_ready_i,
    output logic [AddrWidth-1:0]                upd_addr_o,
    output logic [1:0]                          upd_op_o
);

    localparam int unsigned LineBits  = CachelineWords * WordWidth;
    localparam int unsigned LineBeats = LineBits / DataWidth;
    localparam int unsigned OffBits   = $clog2(LineBits / 8);
    localparam int unsigned BeatBits  = (LineBeats > 1) ? $clog2(LineBeats) : 1;
    localparam logic [BeatBits-1:0] LastBeat = BeatBits'(LineBeats - 1);

    snoop_state_e          state_q;
    logic [AddrWidth-1:0]  addr_q;
    logic [3:0]            snoop_q;
    cr_resp_t              resp_q;
    logic [LineBits-1:0]   line_q;
    logic [BeatBits-1:0]   beat_q;

    logic [AddrWidth-1:0]  aligned_c;
    cr_resp_t              dec_resp_c;
    upd_op_e               dec_op_c;
    logic                  resp_enter_c;
    cr_resp_t              resp_src_c;
    logic [DataWidth-1:0]  beat0_src_c;
    logic [BeatBits-1:0]   beat_nxt_c;
    logic                  cr_done_c;
    logic                  cd_done_c;
    logic                  unused_c;

    // ACPROT and the byte offset inside the line carry no meaning for a snoop.
    assign unused_c  = ^{ac_prot_i, ac_addr_i[OffBits-1:0]};
    assign aligned_c = {ac_addr_i[AddrWidth-1:OffBits], OffBits'(0)};

    // Decision is taken on the live lookup result in the rvalid cycle.
    ace_snoop_decode u_decode (
        .snoop  (snoop_q),
        .hit    (lookup_hit_i),
        .dirty  (lookup_dirty_i),
        .shared (lookup_shared_i),
        .resp_c (dec_resp_c),
        .op_c   (dec_op_c)
    );

    // Entry into RESP comes either straight from the lookup result or after the update handshake.
    always_comb begin
        resp_enter_c = 1'b0;
        resp_src_c   = resp_q;
        beat0_src_c  = line_q[DataWidth-1:0];
        if (state_q == ST_WAIT) begin
            resp_enter_c = lookup_rvalid_i && (dec_op_c == UPD_NONE);
            resp_src_c   = dec_resp_c;
            beat0_src_c  = lookup_data_i[DataWidth-1:0];
        end else if (state_q == ST_UPDATE) begin
            resp_enter_c = upd_ready_i;
        end
    end

    // CR and CD complete independently; RESP ends when both are finished this cycle or earlier.
    assign beat_nxt_c = beat_q + BeatBits'(1);
    assign cr_done_c  = !cr_valid_o || cr_ready_i;
    assign cd_done_c  = !cd_valid_o || (cd_ready_i && cd_last_o);

    // Responder FSM with registered outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            snoop_q       <= '0;
            resp_q        <= '0;
            line_q        <= '0;
            beat_q        <= '0;
            ac_ready_o    <= 1'b1;
            cr_valid_o    <= 1'b0;
            cr_resp_o     <= '0;
            cd_valid_o    <= 1'b0;
            cd_data_o     <= '0;
            cd_last_o     <= 1'b0;
            lookup_req_o  <= 1'b0;
            lookup_addr_o <= '0;
            upd_valid_o   <= 1'b0;
            upd_addr_o    <= '0;
            upd_op_o      <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (ac_valid_i && ac_ready_o) begin
                        addr_q        <= aligned_c;
                        snoop_q       <= ac_snoop_i;
                        ac_ready_o    <= 1'b0;
                        lookup_req_o  <= 1'b1;
                        lookup_addr_o <= aligned_c;
                        state_q       <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (lookup_gnt_i) begin
                        lookup_req_o <= 1'b0;
                        state_q      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lookup_rvalid_i) begin
                        line_q <= lookup_data_i;
                        resp_q <= dec_resp_c;
                        if (dec_op_c != UPD_NONE) begin
                            upd_valid_o <= 1'b1;
                            upd_addr_o  <= addr_q;
                            upd_op_o    <= dec_op_c;
                            state_q     <= ST_UPDATE;
                        end else begin
                            state_q     <= ST_RESP;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (upd_ready_i) begin
                        upd_valid_o <= 1'b0;
                        upd_op_o    <= '0;
                        state_q     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (cr_valid_o && cr_ready_i) begin
                        cr_valid_o <= 1'b0;
                        cr_resp_o  <= '0;
                    end
                    if (cd_valid_o && cd_ready_i) begin
                        if (cd_last_o) begin
                            cd_valid_o <= 1'b0;
                            cd_last_o  <= 1'b0;
                            beat_q     <= '0;
                        end else begin
                            beat_q    <= beat_nxt_c;
                            cd_data_o <= line_q[int'(beat_nxt_c) * DataWidth +: DataWidth];
                            cd_last_o <= (beat_nxt_c == LastBeat);
                        end
                    end
                    if (cr_done_c && cd_done_c) begin
                        ac_ready_o <= 1'b1;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            // Response launch: CR and the first CD beat rise together.
            if (resp_enter_c) begin
                cr_valid_o <= 1'b1;
                cr_resp_o  <= resp_src_c;
                cd_valid_o <= resp_src_c.data_transfer;
                cd_data_o  <= beat0_src_c;
                cd_last_o  <= resp_src_c.data_transfer && (LineBeats == 1);
                beat_q     <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ace_snoop_responder.sv
// Bench for ace_snoop_responder: a behavioural cache answers lookups/updates, a
// scoreboard holds expected lookup, update, CR and CD traffic, and a negedge
// monitor pops and compares as the DUT handshakes.
module tb_ace_snoop_responder;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         ac_valid_i = 1'b0;
    logic         ac_ready_o;
    logic [63:0]  ac_addr_i = '0;
    logic [3:0]   ac_snoop_i = '0;
    logic [2:0]   ac_prot_i = '0;
    logic         cr_valid_o;
    logic         cr_ready_i = 1'b0;
    logic [4:0]   cr_resp_o;
    logic         cd_valid_o;
    logic         cd_ready_i = 1'b0;
    logic [63:0]  cd_data_o;
    logic         cd_last_o;
    logic         lookup_req_o;
    logic         lookup_gnt_i = 1'b0;
    logic [63:0]  lookup_addr_o;
    logic         lookup_rvalid_i = 1'b0;
    logic         lookup_hit_i = 1'b0;
    logic         lookup_dirty_i = 1'b0;
    logic         lookup_shared_i = 1'b0;
    logic [255:0] lookup_data_i = '0;
    logic         upd_valid_o;
    logic         upd_ready_i = 1'b0;
    logic [63:0]  upd_addr_o;
    logic [1:0]   upd_op_o;

    ace_snoop_responder dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ac_valid_i      (ac_valid_i),
        .ac_ready_o      (ac_ready_o),
        .ac_addr_i       (ac_addr_i),
        .ac_snoop_i      (ac_snoop_i),
        .ac_prot_i       (ac_prot_i),
        .cr_valid_o      (cr_valid_o),
        .cr_ready_i      (cr_ready_i),
        .cr_resp_o       (cr_resp_o),
        .cd_valid_o      (cd_valid_o),
        .cd_ready_i      (cd_ready_i),
        .cd_data_o       (cd_data_o),
        .cd_last_o       (cd_last_o),
        .lookup_req_o    (lookup_req_o),
        .lookup_gnt_i    (lookup_gnt_i),
        .lookup_addr_o   (lookup_addr_o),
        .lookup_rvalid_i (lookup_rvalid_i),
        .lookup_hit_i    (lookup_hit_i),
        .lookup_dirty_i  (lookup_dirty_i),
        .lookup_shared_i (lookup_shared_i),
        .lookup_data_i   (lookup_data_i),
        .upd_valid_o     (upd_valid_o),
        .upd_ready_i     (upd_ready_i),
        .upd_addr_o      (upd_addr_o),
        .upd_op_o        (upd_op_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  snoop;
        logic [63:0] addr;
        logic        hit;
        logic        dirty;
        logic        shared;
        logic [63:0] base;   // line word k = base + k
        logic [4:0]  resp;
        logic [1:0]  op;
        int          lat;    // AC handshake edge to cr_valid_o, in cycles, zero-wait cache
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [63:0]  exp_lookup_q[$];
    logic [65:0]  exp_upd_q[$];
    logic [4:0]   exp_cr_q[$];
    logic [64:0]  exp_cd_q[$];

    // Cache model controls.
    logic         cache_hit = 1'b0, cache_dirty = 1'b0, cache_shared = 1'b0;
    logic [255:0] cache_line = '0;
    bit           rand_mode = 1'b0;
    bit           cr_block = 1'b0;
    bit           cd_block = 1'b0;
    int           gnt_wait = 0;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural cache: grants after gnt_wait cycles, returns the line one cycle after grant.
    bit pend = 1'b0;
    int req_cnt = 0;
    always begin
        @(posedge clk); #1;
        if (rst_n) begin
            pend = 1'b0; req_cnt = 0;
            lookup_gnt_i = 1'b0; lookup_rvalid_i = 1'b0;
            lookup_hit_i = 1'b0; lookup_dirty_i = 1'b0; lookup_shared_i = 1'b0;
            lookup_data_i = '0; upd_ready_i = 1'b0; cr_ready_i = 1'b0; cd_ready_i = 1'b0;
        end else begin
            lookup_rvalid_i = pend;
            lookup_hit_i    = pend & cache_hit;
            lookup_dirty_i  = pend & cache_dirty;
            lookup_shared_i = pend & cache_shared;
            lookup_data_i   = pend ? cache_line : '0;
            pend = 1'b0;
            if (lookup_req_o) req_cnt++; else req_cnt = 0;
            lookup_gnt_i = lookup_req_o && (req_cnt > gnt_wait);
            if (lookup_gnt_i) pend = 1'b1;
            upd_ready_i = upd_valid_o && (!rand_mode || ($urandom_range(0, 2) == 0));
            cr_ready_i  = !cr_block && (!rand_mode || ($urandom_range(0, 1) == 1));
            cd_ready_i  = !cd_block && (!rand_mode || ($urandom_range(0, 1) == 1));
        end
    end

    // Scoreboard monitor: pops on each handshake, checks hold-while-stalled and IDLE return.
    bit          cr_stall = 1'b0, cd_stall = 1'b0, prev_ac_ready = 1'b1;
    logic [4:0]  prev_resp;
    logic [64:0] prev_beat;
    always @(negedge clk) begin
        if (rst_n) begin
            cr_stall = 1'b0; cd_stall = 1'b0; prev_ac_ready = 1'b1;
        end else begin
            if (lookup_req_o && lookup_gnt_i) begin
                if (exp_lookup_q.size() == 0) chk("unexpected_lookup", lookup_addr_o, '1);
                else chk("lookup_addr", lookup_addr_o, exp_lookup_q.pop_front());
            end
            if (upd_valid_o && upd_ready_i) begin
                if (exp_upd_q.size() == 0) chk("unexpected_upd", {upd_addr_o, upd_op_o}, '1);
                else chk("upd_addr_op", {upd_addr_o, upd_op_o}, exp_upd_q.pop_front());
            end
            if (cr_valid_o && cr_ready_i) begin
                if (exp_cr_q.size() == 0) chk("unexpected_cr", cr_resp_o, '1);
                else chk("cr_resp", cr_resp_o, exp_cr_q.pop_front());
            end
            if (cd_valid_o && cd_ready_i) begin
                if (exp_cd_q.size() == 0) chk("unexpected_cd", {cd_last_o, cd_data_o}, '1);
                else chk("cd_last_data", {cd_last_o, cd_data_o}, exp_cd_q.pop_front());
            end
            if (cr_stall) chk("cr_hold", {cr_valid_o, cr_resp_o}, {1'b1, prev_resp});
            if (cd_stall) chk("cd_hold", {cd_valid_o, cd_last_o, cd_data_o}, {1'b1, prev_beat});
            cr_stall  = cr_valid_o && !cr_ready_i;
            cd_stall  = cd_valid_o && !cd_ready_i;
            prev_resp = cr_resp_o;
            prev_beat = {cd_last_o, cd_data_o};
            if (ac_ready_o && !prev_ac_ready)
                chk("idle_after_resp_done", 32'(exp_cr_q.size() + exp_cd_q.size()), 0);
            prev_ac_ready = ac_ready_o;
        end
    end

    task automatic start_snoop(input vec_t v);
        logic [255:0] line;
        int n;
        for (int k = 0; k < 4; k++) line[k*64 +: 64] = v.base + 64'(k);
        cache_hit = v.hit; cache_dirty = v.dirty; cache_shared = v.shared; cache_line = line;
        exp_lookup_q.push_back({v.addr[63:5], 5'b0});
        if (v.op != 2'd0) exp_upd_q.push_back({v.addr[63:5], 5'b0, v.op});
        exp_cr_q.push_back(v.resp);
        if (v.resp[0])
            for (int k = 0; k < 4; k++) exp_cd_q.push_back({k == 3, v.base + 64'(k)});
        @(posedge clk); #1;
        ac_addr_i = v.addr; ac_snoop_i = v.snoop; ac_prot_i = 3'($urandom); ac_valid_i = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!ac_ready_o && n < 50);
        chk("ac_ready_for_snoop", ac_ready_o, 1'b1);
        @(posedge clk); #1;
        ac_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        bit ok;
        do begin
            @(negedge clk); #1; n++;
            ok = ac_ready_o && exp_lookup_q.size() == 0 && exp_upd_q.size() == 0 &&
                 exp_cr_q.size() == 0 && exp_cd_q.size() == 0;
        end while (!ok && n < 400);
        chk({name, "_done"}, ok, 1'b1);
        if (!ok) begin
            exp_lookup_q.delete(); exp_upd_q.delete(); exp_cr_q.delete(); exp_cd_q.delete();
        end
    endtask

    task automatic run_snoop(input vec_t v, input bit chk_lat, input string name);
        int lat = 0;
        start_snoop(v);
        while (!cr_valid_o && lat < 200) begin @(negedge clk); lat++; end
        if (chk_lat) chk({name, "_latency"}, lat, v.lat);
        wait_done(name);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ac_ready"}, ac_ready_o, 1'b1);
        chk({name, "_valids"}, {cr_valid_o, cd_valid_o, upd_valid_o, lookup_req_o, cd_last_o}, 5'b0);
        chk({name, "_payloads"}, {cr_resp_o, cd_data_o, upd_op_o}, '0);
        chk({name, "_addrs"}, {lookup_addr_o, upd_addr_o}, '0);
    endtask

    initial begin
        //          snoop    addr          h     d     s     base                   resp      op    lat
        tbl[0]  = '{4'b0001, 64'h1000, 1'b1, 1'b1, 1'b0, 64'hA0,               5'b11101, 2'd1, 4};
        tbl[1]  = '{4'b0111, 64'h2000, 1'b0, 1'b1, 1'b0, 64'hB0,               5'b00000, 2'd0, 3};
        tbl[2]  = '{4'b1001, 64'h3000, 1'b1, 1'b0, 1'b1, 64'hC0,               5'b00000, 2'd3, 4};
        tbl[3]  = '{4'b1001, 64'h3040, 1'b1, 1'b1, 1'b0, 64'hD000_0000_0000_00D0, 5'b10101, 2'd3, 4};
        tbl[4]  = '{4'b0000, 64'h4008, 1'b1, 1'b1, 1'b1, 64'h4400,             5'b01001, 2'd0, 3};
        tbl[5]  = '{4'b0010, 64'h5000, 1'b1, 1'b0, 1'b1, 64'h5500,             5'b01001, 2'd1, 4};
        tbl[6]  = '{4'b0011, 64'h6000, 1'b1, 1'b1, 1'b1, 64'h6600,             5'b01101, 2'd1, 4};
        tbl[7]  = '{4'b0111, 64'h7000, 1'b1, 1'b1, 1'b0, 64'h7700,             5'b10101, 2'd3, 4};
        tbl[8]  = '{4'b1000, 64'h8000, 1'b1, 1'b1, 1'b0, 64'h8800,             5'b11101, 2'd2, 4};
        tbl[9]  = '{4'b1000, 64'h9000, 1'b1, 1'b0, 1'b0, 64'h9900,             5'b11000, 2'd0, 3};
        tbl[10] = '{4'b1101, 64'hA000, 1'b1, 1'b1, 1'b0, 64'hAA00,             5'b10000, 2'd3, 4};
        tbl[11] = '{4'b1111, 64'h1034, 1'b1, 1'b1, 1'b0, 64'hBB00,             5'b00000, 2'd0, 3};
        tbl[12] = '{4'b0001, 64'h2038, 1'b1, 1'b0, 1'b0, 64'hCC00,             5'b11001, 2'd1, 4};
        tbl[13] = '{4'b0100, 64'hE000, 1'b1, 1'b1, 1'b0, 64'hEE00,             5'b00000, 2'd0, 3};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b0;

        // Zero-wait cache with always-ready channels: exact latencies are checked.
        for (int i = 0; i < 14; i++) run_snoop(tbl[i], 1'b1, $sformatf("vec%0d", i));

        // Randomised grant delay and backpressure on every channel.
        rand_mode = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 14; i++) begin
                gnt_wait = $urandom_range(0, 3);
                run_snoop(tbl[i], 1'b0, $sformatf("rnd%0d_%0d", r, i));
            end
        rand_mode = 1'b0;
        gnt_wait  = 0;

        // CD stalled 20 cycles after CR is accepted: data held, no return to IDLE.
        cd_block = 1'b1;
        start_snoop(tbl[0]);
        for (int n = 0; n < 100 && exp_cr_q.size() != 0; n++) @(negedge clk);
        chk("stall_cr_accepted", 32'(exp_cr_q.size()), 0);
        repeat (20) @(negedge clk);
        chk("stall_ac_ready_low", ac_ready_o, 1'b0);
        chk("stall_cd_valid", cd_valid_o, 1'b1);
        chk("stall_beats_left", 32'(exp_cd_q.size()), 4);
        @(posedge clk); #1;
        cd_block = 1'b0;
        wait_done("stall");

        // Reset while CD beat 2 is on the bus, then a fresh ReadOnce.
        start_snoop(tbl[0]);
        for (int n = 0; n < 100 && exp_cd_q.size() != 2; n++) begin @(negedge clk); #1; end
        chk("mid_reset_at_beat2", 32'(exp_cd_q.size()), 2);
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_lookup_q.delete(); exp_upd_q.delete(); exp_cr_q.delete(); exp_cd_q.delete();
        @(negedge clk);
        chk_reset_outputs("mid_reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        run_snoop('{4'b0000, 64'h1000, 1'b1, 1'b1, 1'b0, 64'hF0, 5'b11001, 2'd0, 3}, 1'b1, "post_reset");
        repeat (3) @(negedge clk);
        chk("post_reset_idle", {ac_ready_o, cr_valid_o, cd_valid_o}, 3'b100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
